// File: rtl/axil_pkg.sv
// Shared response codes and FSM encodings for the AXI4-Lite SRAM bank.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rdState_t;

    typedef enum logic [2:0] {
        W_IDLE      = 3'd0,
        W_HAVE_ADDR = 3'd1,
        W_HAVE_DATA = 3'd2,
        W_COMMIT    = 3'd3,
        W_RESP      = 3'd4
    } wrState_t;

endpackage

// File: rtl/sram_byte_array.sv
// Word-organised SRAM: one registered read port, one byte-enabled write port.
module sram_byte_array #(
    parameter int DATA_W   = 128,
    parameter int DEPTH_AW = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdEn,
    input  logic                  rdClr,
    input  logic [DEPTH_AW-1:0]   rdAddr,
    output logic [DATA_W-1:0]     rdData,
    input  logic                  wrEn,
    input  logic [DEPTH_AW-1:0]   wrAddr,
    input  logic [DATA_W-1:0]     wrData,
    input  logic [DATA_W/8-1:0]   wrStrb
);

    logic [DATA_W-1:0] mem [2**DEPTH_AW];
    logic [DATA_W-1:0] rdData_r;

    // Byte-enabled write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wrStrb[b]) begin
                    mem[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

    // Read output register; rdClr returns zero without touching the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_r <= '0;
        end else if (rdEn) begin
            rdData_r <= rdClr ? '0 : mem[rdAddr];
        end
    end

    assign rdData = rdData_r;

endmodule

// File: rtl/axil_sram_bank.sv
// AXI4-Lite slave over a byte-strobed SRAM with range decode and configurable read latency.
module axil_sram_bank
    import axil_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 32,
    parameter int MEM_AW   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   readAddr_addr,
    input  logic                readAddr_valid,
    output logic                readAddr_ready,
    output logic [DATA_W-1:0]   readData_data,
    output logic [1:0]          readData_resp,
    output logic                readData_valid,
    input  logic                readData_ready,
    input  logic [ADDR_W-1:0]   writeAddr_addr,
    input  logic                writeAddr_valid,
    output logic                writeAddr_ready,
    input  logic [DATA_W-1:0]   writeData_data,
    input  logic [DATA_W/8-1:0] writeData_strb,
    input  logic                writeData_valid,
    output logic                writeData_ready,
    output logic [31:0]         writeResp_msg,
    output logic                writeResp_valid,
    input  logic                writeResp_ready
);

    localparam int OFF_W           = $clog2(DATA_W/8);
    localparam int DEPTH_AW        = MEM_AW - OFF_W;
    localparam logic [1:0] RD_LAST = 2'(READ_LAT - 1);

    rdState_t              rdState_r, rdNext_s;
    logic [DEPTH_AW-1:0]   rdIdx_r;
    logic                  rdOor_r;
    logic [1:0]            rdCnt_r;
    logic [1:0]            readResp_r;
    logic                  rdAddrHs_s, rdLast_s, rdEn_s;
    logic [DATA_W-1:0]     sramRd_s;

    wrState_t              wrState_r, wrNext_s;
    logic [DEPTH_AW-1:0]   wrIdx_r;
    logic                  wrOor_r;
    logic [DATA_W-1:0]     wrData_r;
    logic [DATA_W/8-1:0]   wrStrb_r;
    logic [1:0]            wrResp_r;
    logic                  awHs_s, wHs_s, wrEn_s;
    logic                  unusedLowBits_s;

    assign unusedLowBits_s = ^{readAddr_addr[OFF_W-1:0], writeAddr_addr[OFF_W-1:0]};

    assign rdAddrHs_s = readAddr_valid && readAddr_ready;
    assign rdLast_s   = (rdState_r == R_WAIT) && (rdCnt_r == RD_LAST);
    assign rdEn_s     = (rdState_r == R_WAIT) && (rdCnt_r == 2'd0);

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) rdState_r <= R_IDLE;
        else     rdState_r <= rdNext_s;
    end

    // Read FSM next state.
    always_comb begin
        rdNext_s = rdState_r;
        case (rdState_r)
            R_IDLE:  if (readAddr_valid) rdNext_s = R_WAIT; else rdNext_s = R_IDLE;
            R_WAIT:  if (rdLast_s) rdNext_s = R_RESP; else rdNext_s = R_WAIT;
            R_RESP:  if (readData_ready) rdNext_s = R_IDLE; else rdNext_s = R_RESP;
            default: rdNext_s = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        readAddr_ready = (rdState_r == R_IDLE);
        readData_valid = (rdState_r == R_RESP);
        readData_resp  = readResp_r;
    end

    // Read address latch, latency counter and response code.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdIdx_r    <= '0;
            rdOor_r    <= 1'b0;
            rdCnt_r    <= 2'd0;
            readResp_r <= RESP_OKAY;
        end else begin
            if (rdAddrHs_s) begin
                rdIdx_r <= readAddr_addr[MEM_AW-1:OFF_W];
                rdOor_r <= |readAddr_addr[ADDR_W-1:MEM_AW];
                rdCnt_r <= 2'd0;
            end else if (rdState_r == R_WAIT) begin
                rdCnt_r <= rdCnt_r + 2'd1;
            end
            if (rdLast_s) readResp_r <= rdOor_r ? RESP_SLVERR : RESP_OKAY;
        end
    end

    generate
        if (READ_LAT > 1) begin : gPipe
            logic [DATA_W-1:0] pipe_r [READ_LAT-1];
            // Extra latency stages advance only while waiting, so data holds in R_RESP.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < READ_LAT-1; k++) pipe_r[k] <= '0;
                end else if (rdState_r == R_WAIT) begin
                    pipe_r[0] <= sramRd_s;
                    for (int k = 1; k < READ_LAT-1; k++) pipe_r[k] <= pipe_r[k-1];
                end
            end
            assign readData_data = pipe_r[READ_LAT-2];
        end else begin : gNoPipe
            assign readData_data = sramRd_s;
        end
    endgenerate

    assign awHs_s = writeAddr_valid && writeAddr_ready;
    assign wHs_s  = writeData_valid && writeData_ready;
    assign wrEn_s = (wrState_r == W_COMMIT) && !wrOor_r;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) wrState_r <= W_IDLE;
        else     wrState_r <= wrNext_s;
    end

    // Write FSM next state; address and data may arrive in any order.
    always_comb begin
        wrNext_s = wrState_r;
        case (wrState_r)
            W_IDLE: begin
                if (awHs_s && wHs_s) wrNext_s = W_COMMIT;
                else if (awHs_s)     wrNext_s = W_HAVE_ADDR;
                else if (wHs_s)      wrNext_s = W_HAVE_DATA;
                else                 wrNext_s = W_IDLE;
            end
            W_HAVE_ADDR: if (wHs_s) wrNext_s = W_COMMIT; else wrNext_s = W_HAVE_ADDR;
            W_HAVE_DATA: if (awHs_s) wrNext_s = W_COMMIT; else wrNext_s = W_HAVE_DATA;
            W_COMMIT:    wrNext_s = W_RESP;
            W_RESP:      if (writeResp_ready) wrNext_s = W_IDLE; else wrNext_s = W_RESP;
            default:     wrNext_s = W_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        writeAddr_ready = (wrState_r == W_IDLE) || (wrState_r == W_HAVE_DATA);
        writeData_ready = (wrState_r == W_IDLE) || (wrState_r == W_HAVE_ADDR);
        writeResp_valid = (wrState_r == W_RESP);
        writeResp_msg   = {30'd0, wrResp_r};
    end

    // Write address/data latches and response code.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrIdx_r  <= '0;
            wrOor_r  <= 1'b0;
            wrData_r <= '0;
            wrStrb_r <= '0;
            wrResp_r <= RESP_OKAY;
        end else begin
            if (awHs_s) begin
                wrIdx_r <= writeAddr_addr[MEM_AW-1:OFF_W];
                wrOor_r <= |writeAddr_addr[ADDR_W-1:MEM_AW];
            end
            if (wHs_s) begin
                wrData_r <= writeData_data;
                wrStrb_r <= writeData_strb;
            end
            if (wrState_r == W_COMMIT) wrResp_r <= wrOor_r ? RESP_SLVERR : RESP_OKAY;
        end
    end

    sram_byte_array #(
        .DATA_W   (DATA_W),
        .DEPTH_AW (DEPTH_AW)
    ) uArray (
        .clk    (clk),
        .rst    (rst),
        .rdEn   (rdEn_s),
        .rdClr  (rdOor_r),
        .rdAddr (rdIdx_r),
        .rdData (sramRd_s),
        .wrEn   (wrEn_s),
        .wrAddr (wrIdx_r),
        .wrData (wrData_r),
        .wrStrb (wrStrb_r)
    );

endmodule

// File: tb/tb_axil_sram_bank.sv
// Table-driven scoreboard bench for axil_sram_bank (READ_LAT=1 and READ_LAT=3 instances).
module tb_axil_sram_bank;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  readAddr_addr, writeAddr_addr;
    logic         readAddr_valid, readAddr_ready, readData_valid, readData_ready;
    logic [127:0] readData_data, writeData_data;
    logic [1:0]   readData_resp;
    logic         writeAddr_valid, writeAddr_ready, writeData_valid, writeData_ready;
    logic [15:0]  writeData_strb;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid, writeResp_ready;

    logic [31:0]  r3Addr;
    logic         r3AValid, r3AReady, r3DValid, r3DReady;
    logic [127:0] r3Data;
    logic [1:0]   r3Resp;
    logic         w3AReady, w3DReady, w3BValid;
    logic [31:0]  w3Msg;

    axil_sram_bank dut (
        .clk(clk), .rst(rst),
        .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
        .readData_data(readData_data), .readData_resp(readData_resp),
        .readData_valid(readData_valid), .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
    );

    axil_sram_bank #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .readAddr_addr(r3Addr), .readAddr_valid(r3AValid), .readAddr_ready(r3AReady),
        .readData_data(r3Data), .readData_resp(r3Resp),
        .readData_valid(r3DValid), .readData_ready(r3DReady),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(w3AReady),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid), .writeData_ready(w3DReady),
        .writeResp_msg(w3Msg), .writeResp_valid(w3BValid), .writeResp_ready(writeResp_ready)
    );

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
    } rdExp_t;
    rdExp_t       rq[$];
    logic [1:0]   bq[$];

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
        logic [127:0] expData;
        logic [1:0]   expResp;
    } vec_t;
    vec_t tbl[16];

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] D3 = 128'hCAFEF00DDEADBEEF1234567890ABCDEF;
    localparam logic [127:0] ONES = {128{1'b1}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nErrors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                           input logic [1:0] expR, input string name);
        bit awDone, wDone, ok;
        logic [1:0] e;
        bq.push_back(expR);
        writeAddr_addr = a; writeAddr_valid = 1'b1;
        writeData_data = d; writeData_strb = s; writeData_valid = 1'b1;
        writeResp_ready = 1'b1;
        awDone = 1'b0; wDone = 1'b0;
        for (int n = 0; n < 50 && !(awDone && wDone); n++) begin
            @(negedge clk);
            if (writeAddr_valid && writeAddr_ready) awDone = 1'b1;
            if (writeData_valid && writeData_ready) wDone = 1'b1;
            @(posedge clk); #1;
            if (awDone) writeAddr_valid = 1'b0;
            if (wDone) writeData_valid = 1'b0;
        end
        writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (writeResp_valid) begin ok = 1'b1; break; end
        end
        e = bq.pop_front();
        if (!ok) timeoutFail({name, "_bresp"});
        else begin
            chk({name, "_bresp"}, writeResp_msg, {30'd0, e});
            chk({name, "_bresp3"}, w3Msg, {30'd0, e});
        end
        @(posedge clk); #1;
        writeResp_ready = 1'b0;
    endtask

    task automatic doRead(input logic [31:0] a, input logic [127:0] expD, input logic [1:0] expR,
                          input string name);
        int t;
        bit ok;
        rdExp_t e;
        e.data = expD; e.resp = expR;
        rq.push_back(e);
        readAddr_addr = a; readAddr_valid = 1'b1; readData_ready = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (readAddr_ready) begin ok = 1'b1; break; end
        end
        t = cyc;
        @(posedge clk); #1;
        readAddr_valid = 1'b0;
        if (!ok) begin
            timeoutFail({name, "_ar"});
            e = rq.pop_front();
            return;
        end
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (readData_valid) begin ok = 1'b1; break; end
        end
        e = rq.pop_front();
        if (!ok) timeoutFail({name, "_r"});
        else begin
            chk({name, "_data"}, readData_data, e.data);
            chk({name, "_resp"}, readData_resp, e.resp);
            chk({name, "_lat"}, cyc - t, 2);
        end
        @(posedge clk); #1;
        readData_ready = 1'b0;
    endtask

    task automatic doRead3(input logic [31:0] a, input logic [127:0] expD, input logic [1:0] expR,
                           input string name);
        int t;
        bit ok;
        r3Addr = a; r3AValid = 1'b1; r3DReady = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (r3AReady) begin ok = 1'b1; break; end
        end
        t = cyc;
        @(posedge clk); #1;
        r3AValid = 1'b0;
        ok = ok && 1'b1;
        for (int n = 0; n < 50 && ok; n++) begin
            @(negedge clk);
            if (r3DValid) break;
            if (n == 49) ok = 1'b0;
        end
        if (!ok) timeoutFail(name);
        else begin
            chk({name, "_data"}, r3Data, expD);
            chk({name, "_resp"}, r3Resp, expR);
            chk({name, "_lat"}, cyc - t, 4);
        end
        @(posedge clk); #1;
        r3DReady = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0010, D1, 16'hFFFF, 128'd0, 2'b00};
        tbl[1]  = '{1'b0, 32'h0000_0010, 128'd0, 16'h0, D1, 2'b00};
        tbl[2]  = '{1'b1, 32'h0000_0020, ONES, 16'hFFFF, 128'd0, 2'b00};
        tbl[3]  = '{1'b1, 32'h0000_0020, 128'd0, 16'h00FF, 128'd0, 2'b00};
        tbl[4]  = '{1'b0, 32'h0000_0020, 128'd0, 16'h0, {64'hFFFFFFFFFFFFFFFF, 64'd0}, 2'b00};
        tbl[5]  = '{1'b1, 32'h0000_0000, {16{8'hA5}}, 16'hFFFF, 128'd0, 2'b00};
        tbl[6]  = '{1'b0, 32'h0001_0000, 128'd0, 16'h0, 128'd0, 2'b10};
        tbl[7]  = '{1'b1, 32'h0001_0000, {16{8'h11}}, 16'hFFFF, 128'd0, 2'b10};
        tbl[8]  = '{1'b0, 32'h0000_0000, 128'd0, 16'h0, {16{8'hA5}}, 2'b00};
        tbl[9]  = '{1'b0, 32'h0000_001F, 128'd0, 16'h0, D1, 2'b00};
        tbl[10] = '{1'b1, 32'h0000_0030, 128'd0, 16'hFFFF, 128'd0, 2'b00};
        tbl[11] = '{1'b1, 32'h0000_003C, {16{8'h77}}, 16'hF000, 128'd0, 2'b00};
        tbl[12] = '{1'b0, 32'h0000_0030, 128'd0, 16'h0, {32'h77777777, 96'd0}, 2'b00};
        tbl[13] = '{1'b0, 32'h8000_0010, 128'd0, 16'h0, 128'd0, 2'b10};
        tbl[14] = '{1'b1, 32'h0000_0010, {16{8'hCC}}, 16'h0000, 128'd0, 2'b00};
        tbl[15] = '{1'b0, 32'h0000_0010, 128'd0, 16'h0, D1, 2'b00};

        rst = 1'b1;
        readAddr_addr = 32'd0; readAddr_valid = 1'b0; readData_ready = 1'b0;
        writeAddr_addr = 32'd0; writeAddr_valid = 1'b0;
        writeData_data = 128'd0; writeData_strb = 16'd0; writeData_valid = 1'b0;
        writeResp_ready = 1'b0;
        r3Addr = 32'd0; r3AValid = 1'b0; r3DReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rvalid", readData_valid, 1'b0);
        chk("rst_bvalid", writeResp_valid, 1'b0);
        chk("rst_rdata", readData_data, 128'd0);
        chk("rst_rresp", readData_resp, 2'b00);
        chk("rst_bmsg", writeResp_msg, 32'd0);
        chk("rst_arready", readAddr_ready, 1'b1);
        chk("rst_awready", writeAddr_ready, 1'b1);
        chk("rst_wready", writeData_ready, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) doWrite(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].expResp, $sformatf("vec%0d", i));
            else           doRead(tbl[i].addr, tbl[i].expData, tbl[i].expResp, $sformatf("vec%0d", i));
        end

        // Address three cycles ahead of data, response held off for four cycles
        writeResp_ready = 1'b0;
        writeAddr_addr = 32'h0000_0040; writeAddr_valid = 1'b1;
        @(negedge clk);
        chk("early_aw_ready", writeAddr_ready, 1'b1);
        @(posedge clk); #1;
        writeAddr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("haveaddr_awready", writeAddr_ready, 1'b0);
            chk("haveaddr_wready", writeData_ready, 1'b1);
            @(posedge clk); #1;
        end
        writeData_data = D2; writeData_strb = 16'hFFFF; writeData_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        writeData_valid = 1'b0;
        writeAddr_addr = 32'h0000_0050; writeAddr_valid = 1'b1;
        @(negedge clk);
        chk("commit_bvalid", writeResp_valid, 1'b0);
        chk("commit_awready", writeAddr_ready, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bhold_valid", writeResp_valid, 1'b1);
            chk("bhold_msg", writeResp_msg, 32'd0);
            chk("bhold_awready", writeAddr_ready, 1'b0);
            @(posedge clk); #1;
        end
        writeResp_ready = 1'b1; writeAddr_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        writeResp_ready = 1'b0;
        @(negedge clk);
        chk("single_commit_bvalid", writeResp_valid, 1'b0);
        @(posedge clk); #1;
        doRead(32'h0000_0040, D2, 2'b00, "early_aw_readback");

        // Read response stalled five cycles
        begin
            int t;
            rdExp_t e;
            bit ok;
            e.data = D2; e.resp = 2'b00;
            rq.push_back(e);
            readAddr_addr = 32'h0000_0040; readAddr_valid = 1'b1; readData_ready = 1'b0;
            @(negedge clk);
            t = cyc;
            @(posedge clk); #1;
            readAddr_valid = 1'b0;
            ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (readData_valid) begin ok = 1'b1; break; end
            end
            e = rq.pop_front();
            if (!ok) timeoutFail("stall_r");
            else begin
                chk("stall_lat", cyc - t, 2);
                for (int k = 0; k < 5; k++) begin
                    chk("stall_valid", readData_valid, 1'b1);
                    chk("stall_data", readData_data, e.data);
                    chk("stall_resp", readData_resp, e.resp);
                    chk("stall_arready", readAddr_ready, 1'b0);
                    @(posedge clk); #1;
                    if (k < 4) @(negedge clk);
                end
            end
            readData_ready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            readData_ready = 1'b0;
            @(negedge clk);
            chk("stall_release_valid", readData_valid, 1'b0);
            chk("stall_release_arready", readAddr_ready, 1'b1);
            @(posedge clk); #1;
        end

        // READ_LAT=3 instance
        doRead3(32'h0000_0010, D1, 2'b00, "lat3_read");
        doRead3(32'h0001_0000, 128'd0, 2'b10, "lat3_oor");

        // Read issued in the commit cycle sees old data; the next read sees new data
        fork
            doWrite(32'h0000_0040, D3, 16'hFFFF, 2'b00, "collide_wr");
            doRead(32'h0000_0040, D2, 2'b00, "collide_rd");
        join
        doRead(32'h0000_0040, D3, 2'b00, "after_collide_rd");

        // Reset while write holds an address and read is waiting on the array
        writeResp_ready = 1'b1; readData_ready = 1'b1;
        writeAddr_addr = 32'h0000_0020; writeAddr_valid = 1'b1;
        readAddr_addr = 32'h0000_0020; readAddr_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        writeAddr_valid = 1'b0; readAddr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", readData_valid, 1'b0);
        chk("midrst_bvalid", writeResp_valid, 1'b0);
        chk("midrst_arready", readAddr_ready, 1'b1);
        chk("midrst_awready", writeAddr_ready, 1'b1);
        chk("midrst_wready", writeData_ready, 1'b1);
        chk("midrst_rdata", readData_data, 128'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_rvalid", readData_valid, 1'b0);
        end
        @(posedge clk); #1;
        writeResp_ready = 1'b0; readData_ready = 1'b0;
        doRead(32'h0000_0020, {64'hFFFFFFFFFFFFFFFF, 64'd0}, 2'b00, "midrst_readback");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/axil_sram_bank.md
Name: axil_sram_bank

Overview:
- Parametrised AXI4-Lite slave wrapping a byte-strobed, word-organised SRAM array.
- Next generation of the fixed 128-bit, 64 KiB scratchpad slave.
- Adds configurable data width, depth and read latency, out-of-range decode with SLVERR, a read-response channel, and a single outstanding transaction per direction.
- Sits on the system interconnect as a memory-mapped scratchpad / instruction memory.

Parameters:
DATA_W, 128, data bus width in bits; power of 2, 32..512.
ADDR_W, 32, bus address width.
MEM_AW, 16, log2 of array size in bytes; decoded window is [0, 2^MEM_AW).
READ_LAT, 1, cycles from array read issue to data capture; 1..4.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
readAddr_addr  in  ADDR_W  read byte address
readAddr_valid  in  1  read address valid
readAddr_ready  out  1  read address accepted
readData_data  out  DATA_W  read data
readData_resp  out  2  00 OKAY, 10 SLVERR
readData_valid  out  1  read data valid
readData_ready  in  1  master accepts read data
writeAddr_addr  in  ADDR_W  write byte address
writeAddr_valid  in  1  write address valid
writeAddr_ready  out  1  write address accepted
writeData_data  in  DATA_W  write data
writeData_strb  in  DATA_W/8  byte enables, bit i maps to data[8i+7:8i]
writeData_valid  in  1  write data valid
writeData_ready  out  1  write data accepted
writeResp_msg  out  32  [1:0] response code, [31:2] zero
writeResp_valid  out  1  write response valid
writeResp_ready  in  1  master accepts response

Behaviour:
- Reset is synchronous (sampled on clk only). Clears all FSMs to idle; clears readData_valid, writeResp_valid, readData_data, readData_resp and writeResp_msg to 0.
- Reset does not clear the array. Any in-flight read or write is dropped; a write not yet committed is not performed.
- Addressing: word index = addr[MEM_AW-1:log2(DATA_W/8)]; low alignment bits ignored. Out-of-range when addr[ADDR_W-1:MEM_AW] != 0.
- Handshake: a transfer occurs on a cycle with valid && ready. Outputs are held stable while valid && !ready.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - readAddr_ready = (state == R_IDLE).
  - On handshake in cycle T: latch word index and range flag; go to R_WAIT; array read issued at T+1.
  - R_WAIT counts READ_LAT cycles. At the last of those edges, capture data and set readData_valid; state becomes R_RESP.
  - With READ_LAT=1, readData_valid is first high in cycle T+2.
  - Out-of-range read: same latency, data 0, resp SLVERR, array not accessed.
  - R_RESP holds until readData_ready, then returns to R_IDLE and clears valid on the next edge. A new address is accepted one cycle later, no bypass.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
  - writeAddr_ready is high in W_IDLE and W_HAVE_DATA.
  - writeData_ready is high in W_IDLE and W_HAVE_ADDR.
  - Address and data may arrive in either order or in the same cycle. Each is latched on its handshake; strb is latched with data.
  - When both are held, go to W_COMMIT. The commit edge writes the array with latched strobes; zero strobes means no bytes change.
  - Next edge: writeResp_valid=1 with OKAY, or SLVERR with no write if out-of-range; state W_RESP.
  - W_RESP holds until writeResp_ready, then W_IDLE. No new address or data is accepted in W_COMMIT or W_RESP.
- Read/write collision on the same word: array read and write in the same cycle returns pre-write data. A read issued after the commit cycle returns new data.
- Read and write channels are fully independent; no stalls between them.

Decomposition:
- Package axil_pkg: response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; read and write FSM state encodings.
- Sub-module sram_byte_array (params DATA_W, DEPTH_AW):
  - One synchronous read port with 1-cycle output register.
  - One synchronous write port with per-byte enables.
  - Extra READ_LAT-1 stages are pipelined in the top level.

Test Plan:
- Write full strb to addr 0x0010 with data 0x0123...EF, then read 0x0010 -> readData_data matches, resp 00, valid first in cycle T+2 (READ_LAT=1).
- Write 0xFF..FF, then write 0 with strb 0x00FF, then read -> upper 8 bytes 0xFF, lower 8 bytes 0x00.
- writeAddr handshake 3 cycles before writeData -> single commit; writeResp_valid stays high for 4 cycles with writeResp_ready low; no second address accepted in that window.
- Read of 0x0001_0000 with MEM_AW=16 -> resp SLVERR, data 0. Write to the same address -> writeResp_msg=2, array unchanged (verified by readback).
- readData_ready held low 5 cycles -> data and resp stable, readAddr_ready low throughout. Repeat with READ_LAT=3: valid in cycle T+4.
- rst asserted in W_HAVE_ADDR and in R_WAIT -> next cycle all valid outputs 0, both address readies high, target word unchanged.
